// File: rtl/lsu_req_queue.sv
// Pipelined load/store unit: decodes load/store instructions, buffers memory
// requests in a small FIFO, tracks outstanding loads and returns extended
// writeback data in order. Misaligned accesses trap instead of issuing.
module lsu_req_queue #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   op1_i,
    input  logic [XLEN-1:0]   op2_i,
    input  logic [31:0]       inst_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rsp_valid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              reg_we_o,
    output logic [4:0]        reg_waddr_o,
    output logic [XLEN-1:0]   reg_wdata_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] misalign_addr_o,
    output logic              busy_o
);

    localparam int NB    = XLEN / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [NB-1:0]     be;
        logic [XLEN-1:0]   wdata;
    } req_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] lane;
    } trk_t;

    // ---------------- decode ----------------
    logic [2:0]        funct3;
    logic              is_load, is_store, valid_op, misalign;
    logic [11:0]       imm12;
    logic [ADDR_W-1:0] eff_addr;
    logic [1:0]        lane;
    logic [NB-1:0]     be;
    logic [XLEN-1:0]   wdata;
    logic              unused_rs1;

    assign funct3     = inst_i[14:12];
    assign unused_rs1 = ^inst_i[19:15];
    assign eff_addr   = op1_i[ADDR_W-1:0] + {{(ADDR_W-12){imm12[11]}}, imm12};
    assign lane       = eff_addr[1:0];

    // Classify the instruction and form immediate, byte enables and lane data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        is_load  = 1'b0;
        is_store = 1'b0;
        imm12    = inst_i[31:20];
        be       = '1;
        wdata    = op2_i;
        misalign = 1'b0;
        if (inst_i[6:0] == 7'b0000011)
            is_load = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (inst_i[6:0] == 7'b0100011) begin
            is_store = (funct3 inside {3'b000, 3'b001, 3'b010});
            imm12    = {inst_i[31:25], inst_i[11:7]};
        end
        case (funct3[1:0])
            2'b00: begin
                be    = NB'(1) << lane;
                wdata = {NB{op2_i[7:0]}} << {lane, 3'b000};
            end
            2'b01: begin
                be       = NB'(3) << lane;
                wdata    = {(NB/2){op2_i[15:0]}} << {lane, 3'b000};
                misalign = lane[0];
            end
            default: misalign = (lane != 2'b00);
        endcase
    end

    assign valid_op = is_load || is_store;

    // ---------------- request FIFO ----------------
    req_t             req_mem [DEPTH];
    req_t             req_head;
    logic [PTR_W-1:0] req_wr_ptr, req_rd_ptr;
    logic [PTR_W:0]   req_count, req_ld_cnt, unissued;
    logic             accept, req_push, req_pop, pop_ld;

    logic [PTR_W-1:0] trk_wr_ptr, trk_rd_ptr;
    logic [PTR_W:0]   trk_count;

    assign in_ready_o = (req_count != FULL_CNT) && (trk_count != FULL_CNT);
    assign accept     = in_valid_i && in_ready_o;
    assign req_push   = accept && valid_op && !misalign && !flush_i;
    assign req_head   = req_mem[req_rd_ptr];
    assign req_pop    = mem_req_valid_o && mem_req_ready_i;
    assign pop_ld     = req_pop && !req_head.we;
    assign unissued   = req_ld_cnt - (PTR_W + 1)'(pop_ld);

    assign mem_req_valid_o = (req_count != '0);
    assign mem_addr_o      = mem_req_valid_o ? req_head.addr  : '0;
    assign mem_we_o        = mem_req_valid_o ? req_head.we    : 1'b0;
    assign mem_be_o        = mem_req_valid_o ? req_head.be    : '0;
    assign mem_wdata_o     = mem_req_valid_o ? req_head.wdata : '0;

    // Write accepted requests into storage.
    always_ff @(posedge clk_i) begin
        // NOTE: storage arrays are not reset; outputs are gated by the valid count instead.
        if (req_push)
            req_mem[req_wr_ptr] <= '{addr: {eff_addr[ADDR_W-1:2], 2'b00}, we: is_store, be: be, wdata: wdata};
    end

    // Request FIFO pointers, occupancy and count of queued loads.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
            req_count  <= '0;
            req_ld_cnt <= '0;
        end else if (flush_i) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            req_rd_ptr <= req_wr_ptr;
            req_count  <= '0;
            req_ld_cnt <= '0;
        end else begin
            if (req_push) req_wr_ptr <= req_wr_ptr + PTR_W'(1);
            if (req_pop)  req_rd_ptr <= req_rd_ptr + PTR_W'(1);
            req_count  <= req_count + (PTR_W + 1)'(req_push) - (PTR_W + 1)'(req_pop);
            req_ld_cnt <= req_ld_cnt + (PTR_W + 1)'(req_push && is_load) - (PTR_W + 1)'(pop_ld);
        end
    end

    // ---------------- load tracker ----------------
    trk_t            trk_mem [DEPTH];
    trk_t            trk_head;
    logic [DEPTH-1:0] trk_killed;
    logic            trk_push, trk_pop;
    logic [XLEN-1:0] rsp_shift, rsp_ext;

    assign trk_push = req_push && is_load;
    assign trk_pop  = mem_rsp_valid_i && (trk_count != '0);
    assign trk_head = trk_mem[trk_rd_ptr];

    // Record destination, size/sign and lane of each accepted load.
    always_ff @(posedge clk_i) begin
        if (trk_push)
            trk_mem[trk_wr_ptr] <= '{rd: inst_i[11:7], funct3: funct3, lane: lane};
    end

    // Tracker pointers and kill flags; flush drops un-issued tail entries.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trk_wr_ptr <= '0;
            trk_rd_ptr <= '0;
            trk_count  <= '0;
            trk_killed <= '0;
        end else begin
            if (trk_pop) trk_rd_ptr <= trk_rd_ptr + PTR_W'(1);
            if (flush_i) begin
                trk_wr_ptr <= trk_wr_ptr - PTR_W'(unissued);
                trk_count  <= trk_count - unissued - (PTR_W + 1)'(trk_pop);
                trk_killed <= '1;
            end else begin
                if (trk_push) begin
                    trk_wr_ptr             <= trk_wr_ptr + PTR_W'(1);
                    trk_killed[trk_wr_ptr] <= 1'b0;
                end
                trk_count <= trk_count + (PTR_W + 1)'(trk_push) - (PTR_W + 1)'(trk_pop);
            end
        end
    end

    // Select the addressed byte/half and extend it.
    always_comb begin
        rsp_shift = mem_rdata_i >> {trk_head.lane, 3'b000};
        case (trk_head.funct3)
            3'b000:  rsp_ext = {{(XLEN-8){rsp_shift[7]}}, rsp_shift[7:0]};
            3'b001:  rsp_ext = {{(XLEN-16){rsp_shift[15]}}, rsp_shift[15:0]};
            3'b100:  rsp_ext = {{(XLEN-8){1'b0}}, rsp_shift[7:0]};
            3'b101:  rsp_ext = {{(XLEN-16){1'b0}}, rsp_shift[15:0]};
            default: rsp_ext = mem_rdata_i;
        endcase
    end

    // Registered writeback and misalignment trap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reg_we_o        <= 1'b0;
            reg_waddr_o     <= '0;
            reg_wdata_o     <= '0;
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            reg_we_o <= trk_pop && !trk_killed[trk_rd_ptr] && !flush_i && (trk_head.rd != 5'd0);
            if (trk_pop) begin
                reg_waddr_o <= trk_head.rd;
                reg_wdata_o <= rsp_ext;
            end
            misalign_o <= accept && valid_op && misalign;
            if (accept && valid_op && misalign)
                misalign_addr_o <= eff_addr;
        end
    end

    assign busy_o = (req_count != '0) || (trk_count != '0);

endmodule

// File: tb/tb_lsu_req_queue.sv
// Directed self-checking bench for lsu_req_queue (DEPTH = 2).
module tb_lsu_req_queue;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [31:0] op1, op2, inst;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_rsp_valid, reg_we, misalign, busy;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata, misalign_addr;

    int n_checks = 0;
    int n_pass   = 0;

    lsu_req_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op1_i(op1), .op2_i(op2), .inst_i(inst),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rsp_valid_i(mem_rsp_valid), .mem_rdata_i(mem_rdata),
        .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
        .misalign_o(misalign), .misalign_addr_o(misalign_addr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_load(input logic [4:0] rd, input logic [2:0] f3, input logic [11:0] imm);
        return {imm, 5'd1, f3, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_store(input logic [2:0] f3, input logic [11:0] imm);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [31:0] i);
        in_valid = 1'b1;
        op1      = a;
        op2      = d;
        inst     = i;
    endtask

    // Accept one load at 0x1000+imm, let it issue, answer it, check writeback.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [11:0] imm, input logic [31:0] rdata,
                           input logic exp_we, input logic [31:0] exp_data);
        mem_req_ready = 1'b1;
        drive(32'h1000, 32'h0, enc_load(rd, f3, imm));
        step();
        in_valid = 1'b0;
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        step();
        mem_rsp_valid = 1'b0;
        check({tag, "_we"}, {31'b0, reg_we}, {31'b0, exp_we});
        if (exp_we) begin
            check({tag, "_waddr"}, {27'b0, reg_waddr}, {27'b0, rd});
            check({tag, "_wdata"}, reg_wdata, exp_data);
        end
        step();
        check({tag, "_we_drop"}, {31'b0, reg_we}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        op1 = '0; op2 = '0; inst = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        #3;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_reg_we", {31'b0, reg_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // SW 0x1000+8
        mem_req_ready = 1'b1;
        drive(32'h1000, 32'hDEADBEEF, enc_store(3'b010, 12'd8));
        step();
        in_valid = 1'b0;
        check("sw_valid", {31'b0, mem_req_valid}, 32'd1);
        check("sw_addr", mem_addr, 32'h1008);
        check("sw_we", {31'b0, mem_we}, 32'd1);
        check("sw_be", {28'b0, mem_be}, 32'hF);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        check("sw_drained", {31'b0, mem_req_valid}, 32'd0);
        check("sw_busy", {31'b0, busy}, 32'd0);

        // SB at 0x1003
        drive(32'h1000, 32'h000000A5, enc_store(3'b000, 12'd3));
        step();
        in_valid = 1'b0;
        check("sb_addr", mem_addr, 32'h1000);
        check("sb_be", {28'b0, mem_be}, 32'h8);
        check("sb_byte3", {24'b0, mem_wdata[31:24]}, 32'hA5);
        step();

        // LB at 0x1003 issue shape, then extension cases
        drive(32'h1000, 32'h0, enc_load(5'd5, 3'b000, 12'd3));
        step();
        in_valid = 1'b0;
        check("lb_we", {31'b0, mem_we}, 32'd0);
        check("lb_be", {28'b0, mem_be}, 32'h8);
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h80123456;
        step();
        mem_rsp_valid = 1'b0;
        check("lb_reg_we", {31'b0, reg_we}, 32'd1);
        check("lb_waddr", {27'b0, reg_waddr}, 32'd5);
        check("lb_wdata", reg_wdata, 32'hFFFFFF80);
        step();
        do_load("lbu", 5'd6, 3'b100, 12'd3, 32'h80123456, 1'b1, 32'h00000080);
        do_load("lh", 5'd7, 3'b001, 12'd2, 32'h8001ABCD, 1'b1, 32'hFFFF8001);
        do_load("lhu", 5'd8, 3'b101, 12'd2, 32'h8001ABCD, 1'b1, 32'h00008001);
        do_load("lw", 5'd9, 3'b010, 12'd4, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);
        do_load("lw_x0", 5'd0, 3'b010, 12'd4, 32'h12345678, 1'b0, 32'h0);
        check("x0_busy", {31'b0, busy}, 32'd0);

        // Response with empty tracker is ignored
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        check("orphan_rsp", {31'b0, reg_we}, 32'd0);

        // Unsupported opcode is accepted and dropped
        drive(32'h1000, 32'h0, 32'h00208033);
        step();
        in_valid = 1'b0;
        check("bad_op_valid", {31'b0, mem_req_valid}, 32'd0);
        check("bad_op_busy", {31'b0, busy}, 32'd0);

        // Misaligned LH at 0x1001 and LW at 0x1002
        drive(32'h1000, 32'h0, enc_load(5'd3, 3'b001, 12'd1));
        step();
        in_valid = 1'b0;
        check("lh_mis_pulse", {31'b0, misalign}, 32'd1);
        check("lh_mis_addr", misalign_addr, 32'h1001);
        check("lh_mis_noreq", {31'b0, mem_req_valid}, 32'd0);
        check("lh_mis_busy", {31'b0, busy}, 32'd0);
        step();
        check("mis_pulse_end", {31'b0, misalign}, 32'd0);
        check("mis_addr_hold", misalign_addr, 32'h1001);
        drive(32'h1000, 32'h0, enc_load(5'd3, 3'b010, 12'd2));
        step();
        in_valid = 1'b0;
        check("lw_mis_pulse", {31'b0, misalign}, 32'd1);
        check("lw_mis_addr", misalign_addr, 32'h1002);
        check("lw_mis_noreq", {31'b0, mem_req_valid}, 32'd0);
        step();

        // Back-pressure: three loads, only two accepted
        mem_req_ready = 1'b0;
        drive(32'h1000, 32'h0, enc_load(5'd10, 3'b010, 12'h010));
        step();
        check("bp_ready1", {31'b0, in_ready}, 32'd1);
        drive(32'h1000, 32'h0, enc_load(5'd11, 3'b010, 12'h014));
        step();
        check("bp_full", {31'b0, in_ready}, 32'd0);
        check("bp_addr0", mem_addr, 32'h1010);
        drive(32'h1000, 32'h0, enc_load(5'd12, 3'b010, 12'h018));
        step();
        check("bp_stall_ready", {31'b0, in_ready}, 32'd0);
        check("bp_stable_addr", mem_addr, 32'h1010);
        check("bp_stable_valid", {31'b0, mem_req_valid}, 32'd1);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        check("bp_drain_addr1", mem_addr, 32'h1014);
        step();
        check("bp_drained", {31'b0, mem_req_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h11111111;
        step();
        check("bp_rsp1_rd", {27'b0, reg_waddr}, 32'd10);
        check("bp_rsp1_data", reg_wdata, 32'h11111111);
        mem_rdata = 32'h22222222;
        step();
        mem_rsp_valid = 1'b0;
        check("bp_rsp2_rd", {27'b0, reg_waddr}, 32'd11);
        check("bp_rsp2_we", {31'b0, reg_we}, 32'd1);
        step();
        check("bp_idle_busy", {31'b0, busy}, 32'd0);
        check("bp_idle_ready", {31'b0, in_ready}, 32'd1);

        // Flush after two loads issued: responses are swallowed
        drive(32'h1000, 32'h0, enc_load(5'd13, 3'b010, 12'h020));
        step();
        drive(32'h1000, 32'h0, enc_load(5'd14, 3'b010, 12'h024));
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_busy_held", {31'b0, busy}, 32'd1);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h33333333;
        step();
        check("fl_rsp1_we", {31'b0, reg_we}, 32'd0);
        check("fl_rsp1_busy", {31'b0, busy}, 32'd1);
        step();
        mem_rsp_valid = 1'b0;
        check("fl_rsp2_we", {31'b0, reg_we}, 32'd0);
        check("fl_rsp2_busy", {31'b0, busy}, 32'd0);

        // Flush of an un-issued load removes it entirely
        mem_req_ready = 1'b0;
        drive(32'h1000, 32'h0, enc_load(5'd15, 3'b010, 12'h028));
        step();
        in_valid = 1'b0;
        check("fl_q_valid", {31'b0, mem_req_valid}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_q_empty", {31'b0, mem_req_valid}, 32'd0);
        check("fl_q_busy", {31'b0, busy}, 32'd0);
        do_load("post_flush", 5'd16, 3'b010, 12'h02C, 32'h44444444, 1'b1, 32'h44444444);

        // Asynchronous reset in the middle of a stall
        mem_req_ready = 1'b0;
        drive(32'h1000, 32'h12345678, enc_store(3'b010, 12'h030));
        step();
        in_valid = 1'b0;
        check("rs_stall_valid", {31'b0, mem_req_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rs_addr", mem_addr, 32'd0);
        check("rs_wdata", mem_wdata, 32'd0);
        check("rs_mis_addr", misalign_addr, 32'd0);
        check("rs_busy", {31'b0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rs_ready_after", {31'b0, in_ready}, 32'd1);
        check("rs_valid_after", {31'b0, mem_req_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_req_queue.md
Name: lsu_req_queue

Overview:
Pipelined load/store unit that replaces the combinational load/store execute path. It accepts decoded load/store instructions from ID through a valid/ready handshake, then computes the effective address, byte enables and lane-aligned store data. Requests are buffered in a DEPTH-entry FIFO toward memory. In-order load responses are tracked, and sign/zero-extended writeback data is returned to the register file. Misaligned accesses are trapped rather than issued.

Parameters:
XLEN, 32, data and operand width (32 only; byte lanes = XLEN/8 = 4)
ADDR_W, 32, address width
DEPTH, 2, request FIFO depth and max outstanding loads (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  discard queued, un-issued requests; suppress writeback of issued loads
in_valid_i  in  1  instruction valid from ID
in_ready_o  out  1  unit can accept an instruction
op1_i  in  XLEN  base register value (rs1)
op2_i  in  XLEN  store data (rs2)
inst_i  in  32  raw instruction
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_we_o  out  1  1 = store, 0 = load
mem_be_o  out  XLEN/8  byte enables
mem_wdata_o  out  XLEN  lane-shifted store data
mem_rsp_valid_i  in  1  load data valid (in order)
mem_rdata_i  in  XLEN  full load word
reg_we_o  out  1  writeback strobe (1-cycle pulse)
reg_waddr_o  out  5  destination register
reg_wdata_o  out  XLEN  extended load data
misalign_o  out  1  misaligned-access trap pulse
misalign_addr_o  out  ADDR_W  faulting effective address
busy_o  out  1  requests queued or loads outstanding

Behaviour:
- Reset (rst_n_i low, async): both FIFOs empty. All outputs are 0, except in_ready_o = 1.
- Effective address: op1_i + sign-extended immediate. Stores (opcode 0100011) use {inst[31:25],inst[11:7]}. Loads (opcode 0000011) use inst[31:20]. Sum wraps modulo 2^ADDR_W.
- Supported funct3: SB/SH/SW = 000/001/010; LB/LH/LW/LBU/LHU = 000/001/010/100/101.
- Other opcodes or funct3 are accepted and dropped, with no side effects.
- Misalignment: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
  - The instruction is accepted but not enqueued.
  - misalign_o pulses 1 cycle after acceptance, with misalign_addr_o = effective address.
  - misalign_addr_o holds its value until the next trap.
- Byte enables: SB/LB* = 0001<<addr[1:0]. SH/LH* = 0011<<addr[1:0]. Word = 1111.
- Store data: SB/SH data is replicated then shifted to the addressed lane.
- Handshake:
  - in_ready_o = !req_full && !(ld_track_full).
  - Transfer on in_valid_i && in_ready_o.
  - An accepted access is registered into the request FIFO and becomes visible on mem_req_* the next cycle (1-cycle latency, head entry drives outputs).
  - Head is popped on mem_req_valid_o && mem_req_ready_i.
  - Outputs hold stable while valid && !ready.
  - Simultaneous push and pop when full is not allowed (in_ready_o is already 0).
- Load tracking FIFO (DEPTH entries): holds rd, funct3 and addr[1:0].
  - Pushed when a load is accepted; popped on mem_rsp_valid_i.
  - On each response, the byte/half is selected by addr[1:0] and sign- or zero-extended per funct3.
  - reg_we_o/reg_waddr_o/reg_wdata_o are registered: they pulse 1 cycle after mem_rsp_valid_i.
  - A load to rd = x0 still tracks and pops, but reg_we_o stays 0.
  - mem_rsp_valid_i with an empty tracker is ignored.
- flush_i (synchronous, takes priority over a same-cycle push):
  - Empties the request FIFO.
  - Every issued-but-unanswered load is marked killed: its response pops the tracker with no writeback.
  - Tracker entries for flushed, un-issued loads are removed.
  - An in-flight pop handshake in the same cycle still completes.
- busy_o = request FIFO or tracker non-empty.

Test Plan:
- SW: op1=0x1000, imm=8, op2=0xDEADBEEF, ready=1 -> next cycle addr=0x1008, we=1, be=1111, wdata=0xDEADBEEF.
- SB at 0x1003 with op2=0x000000A5 -> be=1000, wdata byte3=0xA5. Response-side LB at 0x1003, rdata=0x80xxxxxx -> reg_wdata=0xFFFFFF80. LBU returns 0x00000080, 1 cycle after rsp.
- LH at 0x1001 -> no mem request, misalign_o pulse, misalign_addr_o=0x1001. LW at 0x1002 -> same behaviour.
- mem_req_ready_i held 0 with DEPTH=2 and three loads presented -> two accepted, in_ready_o=0. Outputs stable. Releasing ready drains them in order; responses write rd in issue order.
- Two loads issued, flush_i asserted before responses -> both responses produce reg_we_o=0, busy_o falls after the second response.
- Assert rst_n_i low mid-stall -> all outputs 0 immediately, in_ready_o=1 after release.
